// File: rtl/blink_encoder.sv
// Serialises an ANSWER_W-bit value as (answer+1) pulses on blinky, then a GAP_CYC low gap.
// Latency: blinky rises the cycle after start is accepted. Backpressure: start is ignored while busy.
module blink_encoder #(
    parameter int ANSWER_W = 3,
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 4,
    parameter int GAP_CYC  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ANSWER_W-1:0] answer,
    output logic                blinky,
    output logic                busy,
    output logic                done
);

    localparam int MAX_HL  = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int MAX_CYC = (MAX_HL > GAP_CYC) ? MAX_HL : GAP_CYC;
    localparam int PW      = $clog2(MAX_CYC + 1);

    // Phase counter holds "cycles remaining minus one" so zero marks the last cycle.
    localparam logic [PW-1:0] HIGH_LD = PW'(HIGH_CYC - 1);
    localparam logic [PW-1:0] LOW_LD  = PW'(LOW_CYC - 1);
    localparam logic [PW-1:0] GAP_LD  = PW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_phase;
    logic [ANSWER_W-1:0] r_cnt_left;
    logic                r_blinky;
    logic                r_busy;
    logic                r_done;

    logic w_phase_end;
    logic w_last_pulse;

    assign w_phase_end  = (r_phase == '0);
    assign w_last_pulse = (r_cnt_left == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_cnt_left <= '0;
            r_blinky   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt_left <= answer;
                        r_phase    <= HIGH_LD;
                        r_state    <= S_HIGH;
                        r_blinky   <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_blinky <= 1'b0;
                        if (w_last_pulse) begin
                            r_phase <= GAP_LD;
                            r_state <= S_GAP;
                        end else begin
                            r_cnt_left <= r_cnt_left - 1'b1;
                            r_phase    <= LOW_LD;
                            r_state    <= S_LOW;
                        end
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                S_LOW: begin
                    if (w_phase_end) begin
                        r_phase  <= HIGH_LD;
                        r_state  <= S_HIGH;
                        r_blinky <= 1'b1;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                S_GAP: begin
                    // done and the busy drop land in the same cycle the FSM re-enters IDLE.
                    if (w_phase_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_blinky <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign blinky = r_blinky;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_blink_encoder.sv
// Directed and randomised bench for blink_encoder against a frame-position reference model.
module tb_blink_encoder;

    localparam int AW = 3;
    localparam int H  = 4;
    localparam int L  = 4;
    localparam int G  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] answer = '0;
    logic          blinky, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    blink_encoder #(.ANSWER_W(AW), .HIGH_CYC(H), .LOW_CYC(L), .GAP_CYC(G)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .answer(answer),
        .blinky(blinky),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int flen(input int a);
        return (a + 1) * H + a * L + G;
    endfunction

    // Reference model: position m_t within the accepted frame.
    logic m_act, m_done;
    int   m_t, m_ans;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_done <= 1'b0; m_t <= 0; m_ans <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_act) begin
                if (start) begin
                    m_act <= 1'b1; m_t <= 0; m_ans <= int'(answer);
                end
            end else if (m_t == flen(m_ans) - 1) begin
                m_act <= 1'b0; m_done <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    int  tot_pulses = 0, tot_busy = 0, tot_done = 0;
    int  hirun = 0, lowrun = 0, fpulses = 0, last_gap = 0;
    int  frame_q[$];
    logic prev_b = 1'b0;
    logic exp_b;

    always @(negedge clk) begin
        exp_b = m_act && (m_t < m_ans * (H + L) + H) && ((m_t % (H + L)) < H);
        chk("cyc", {29'd0, blinky, busy, done}, {29'd0, exp_b, m_act, m_done});
        if (rst) begin
            hirun = 0; lowrun = 0; fpulses = 0; prev_b = 1'b0;
        end else begin
            if (busy) tot_busy++;
            if (done) begin
                tot_done++;
                last_gap = lowrun;
                frame_q.push_back(fpulses);
                lowrun = 0; fpulses = 0;
            end
            if (blinky) begin
                if (!prev_b) begin tot_pulses++; fpulses++; end
                hirun++; lowrun = 0;
            end else begin
                if (hirun > 0) begin chk("hi_width", hirun, H); hirun = 0; end
                if (busy) lowrun++;
            end
            prev_b = blinky;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (!done && n < max);
        chk(tag, done, 1);
    endtask

    int bp, bb, bd, bq, exp_p;

    initial begin
        // Reset state
        tick(3);
        chk("rst_blinky", blinky, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick(2);
        chk("idle_busy", busy, 0);

        // 1: answer=0
        bp = tot_pulses; bb = tot_busy; bd = tot_done;
        answer = 3'd0; start = 1'b1; tick(1); start = 1'b0;
        wait_done("t1_done_seen", 100);
        tick(5);
        chk("t1_pulses", tot_pulses - bp, 1);
        chk("t1_busy", tot_busy - bb, 20);
        chk("t1_done", tot_done - bd, 1);
        chk("t1_gap", last_gap, G);
        chk("t1_blinky_after", blinky, 0);

        // 2: answer=7, receiver decodes pulses-1
        bp = tot_pulses; bb = tot_busy; bd = tot_done;
        answer = 3'd7; start = 1'b1; tick(1); start = 1'b0;
        wait_done("t2_done_seen", 200);
        tick(3);
        chk("t2_pulses", tot_pulses - bp, 8);
        chk("t2_busy", tot_busy - bb, 76);
        chk("t2_done", tot_done - bd, 1);
        chk("t2_rx_value", tot_pulses - bp - 1, 7);

        // 3: start held high, back-to-back frames, answer changed mid-frame
        bq = frame_q.size();
        answer = 3'd3; start = 1'b1;
        wait_done("t3_f1", 200);
        chk("t3_f1_gap", last_gap, G);
        wait_done("t3_f2", 200);
        chk("t3_f2_gap", last_gap, G);
        tick(1);
        chk("t3_restart", blinky, 1);
        tick(9);
        answer = 3'd1;
        wait_done("t3_f3", 200);
        wait_done("t3_f4", 200);
        start = 1'b0;
        chk("t3_f4_gap", last_gap, G);
        tick(3);
        chk("t3_stopped", busy, 0);
        chk("t3_nframes", frame_q.size() - bq, 4);
        if (frame_q.size() - bq == 4) begin
            chk("t3_p1", frame_q[bq], 4);
            chk("t3_p2", frame_q[bq + 1], 4);
            chk("t3_p3", frame_q[bq + 2], 4);
            chk("t3_p4", frame_q[bq + 3], 2);
        end

        // 4: start pulses during HIGH, LOW and GAP are ignored
        bp = tot_pulses; bd = tot_done;
        answer = 3'd2; start = 1'b1; tick(1); start = 1'b0;
        tick(1); answer = 3'd6; start = 1'b1; tick(1); start = 1'b0;
        tick(2); start = 1'b1; tick(1); start = 1'b0;
        tick(16); start = 1'b1; tick(1); start = 1'b0;
        wait_done("t4_done_seen", 100);
        tick(4);
        chk("t4_pulses", tot_pulses - bp, 3);
        chk("t4_done", tot_done - bd, 1);
        chk("t4_idle", busy, 0);

        // 5: async reset mid-HIGH
        bp = tot_pulses; bd = tot_done;
        answer = 3'd5; start = 1'b1; tick(1); start = 1'b0;
        tick(17);
        chk("t5_pre_high", blinky, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_blinky", blinky, 0);
        chk("t5_rst_busy", busy, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("t5_no_done", tot_done - bd, 0);
        bp = tot_pulses;
        answer = 3'd1; start = 1'b1; tick(1); start = 1'b0;
        wait_done("t5_done_seen", 100);
        tick(2);
        chk("t5_pulses", tot_pulses - bp, 2);
        chk("t5_done", tot_done - bd, 1);

        // 6: randomised frames and spacing, cycle-checked against the model
        bp = tot_pulses; bd = tot_done; exp_p = 0;
        for (int i = 0; i < 1000; i++) begin
            answer = AW'($urandom_range(0, 7));
            exp_p += int'(answer) + 1;
            start = 1'b1; tick(1); start = 1'b0;
            if ($urandom_range(0, 1) == 1) answer = AW'($urandom_range(0, 7));
            wait_done("t6_done_seen", 200);
            tick($urandom_range(0, 3));
        end
        tick(3);
        chk("t6_pulses", tot_pulses - bp, exp_p);
        chk("t6_frames", tot_done - bd, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
